serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only when state is not RUN.
REQ-005 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in for add; ignored when sub=1; sampled with start.
REQ-009 SHALL have port busy  output  1  high exactly while state is RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result registers update.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  registered carry-out; on subtract, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  registered two's-complement overflow flag.

Function
REQ-014 SHALL compute the result bit-serially using exactly one instance of the team's one-bit full adder, one bit per clock, LSB first.
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 IDLE or DONE with start=1 at an edge SHALL load the operand shift registers with a and (sub ? ~b : b), load the carry flop with (sub ? 1 : cin), clear the bit counter, and enter RUN.
REQ-017 IDLE with start=0 SHALL remain in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-018 In each RUN cycle:
- adder inputs = operand-A LSB, operand-B LSB, carry flop;
- adder sum bit shifts into the MSB of an internal result shift register (shift right);
- carry flop <= adder cout;
- operand registers shift right;
- counter increments.
REQ-019 On the RUN cycle with counter = WIDTH-1:
- capture the carry flop value (carry into the MSB) for overflow;
- transition to DONE.
REQ-020 On the RUN->DONE edge SHALL load sum <= final result vector, cout <= final carry, and ovf <= (carry into MSB) XOR (final carry).
REQ-021 sum, cout and ovf SHALL hold their previous values at all other times, including throughout RUN.
REQ-022 done SHALL be high only in the DONE state.
REQ-023 Latency: start sampled at edge k -> busy high for cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1.
REQ-024 start during RUN SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-025 start in the DONE cycle SHALL be accepted (back-to-back); done still pulses for the completed result and busy rises in the next cycle.
REQ-026 Operand inputs SHALL NOT affect an operation in flight once sampled.
REQ-027 Results SHALL equal (a + b + cin) mod 2^WIDTH for add and (a - b) mod 2^WIDTH for subtract, for all operand values.

Reset
REQ-028 rst high SHALL immediately and asynchronously force:
- state = IDLE;
- busy, done, sum, cout, ovf, counter, carry flop and all shift registers = 0.
REQ-029 Reset during RUN SHALL abort the operation, and no done pulse SHALL follow.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL begin a new operation normally.

Verification (WIDTH=8)
REQ-031 Add with a=0x0F, b=0x01, cin=0, start at edge k -> busy for 8 cycles, done in cycle k+9, sum=0x10, cout=0, ovf=0.
REQ-032 Add with a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-033 Add with a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; same operands with cin=1 -> sum=0x81, ovf=1.
REQ-034 Subtract:
- a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0;
- a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-035 start pulsed during RUN with different operands -> first result unchanged; start held high through the DONE cycle -> second operation starts and busy rises in the cycle after done.
REQ-036 rst asserted in the 4th RUN cycle -> all outputs 0 immediately; no done pulse afterwards; a subsequent start yields a correct result.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full adder, one result bit per clock,
// LSB first, with IDLE/RUN/DONE sequencing and registered sum/carry/overflow.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_load;
  logic               w_last;
  logic               w_fa_s;
  logic               w_fa_co;

  assign w_load = start && (r_state != RUN);
  assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .i_a  (r_op_a[0]),
    .i_b  (r_op_b[0]),
    .i_ci (r_carry),
    .o_s  (w_fa_s),
    .o_co (w_fa_co)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_load) begin
      // Subtract is a + ~b + 1: invert B and seed the carry with 1.
      r_op_a  <= a;
      r_op_b  <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_op_a  <= r_op_a >> 1;
      r_op_b  <= r_op_b >> 1;
      r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
      r_carry <= w_fa_co;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        // On the MSB cycle the carry flop still holds the carry into the MSB.
        sum  <= {w_fa_s, r_res[WIDTH-1:1]};
        cout <= w_fa_co;
        ovf  <= r_carry ^ w_fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed vectors, queued
// expectations, and a monitor that checks each done pulse.

module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  exp_t exp_q[$];
  exp_t prev;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_done++;
        check($sformatf("sum#%0d", n_done),  32'(sum),  32'(e.s));
        check($sformatf("cout#%0d", n_done), 32'(cout), 32'(e.c));
        check($sformatf("ovf#%0d", n_done),  32'(ovf),  32'(e.o));
      end
    end
  end

  // Present a request at a negedge and queue its expected result.
  task automatic drive(input vec_t v);
    a     = v.a;
    b     = v.b;
    sub   = v.sub;
    cin   = v.cin;
    start = 1'b1;
    exp_q.push_back('{s: v.s, c: v.c, o: v.o});
  endtask

  // Follow an accepted request through RUN and DONE; optionally pulse start
  // with junk operands after RUN cycle 'glitch'.
  task automatic body(input vec_t v, input int glitch);
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
      check($sformatf("done_run%0d", i), 32'(done), 32'd0);
      check($sformatf("sum_hold%0d", i), 32'(sum),  32'(prev.s));
      if (i == glitch) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    @(negedge clk);
    check("busy_done_cycle", 32'(busy), 32'd0);
    check("done_pulse",      32'(done), 32'd1);
    prev = '{s: v.s, c: v.c, o: v.o};
  endtask

  task automatic run(input vec_t v, input int glitch);
    @(negedge clk);
    drive(v);
    body(v, glitch);
  endtask

  vec_t vecs[11];
  vec_t b2b;
  vec_t rv;

  initial begin
    //            a      b    sub   cin   sum   cout  ovf
    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
    vecs[4]  = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[5]  = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[10] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    b2b      = '{8'h3C, 8'hC3, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    rv       = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
    prev     = '{s: '0, c: 1'b0, o: 1'b0};

    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) run(vecs[i], (i == 0) ? 3 : 0);

    // Back-to-back: start presented during the DONE cycle.
    run(vecs[1], 0);
    drive(b2b);
    body(b2b, 0);

    // Reset in the 4th RUN cycle aborts the operation without a done pulse.
    @(negedge clk);
    drive(rv);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    prev = '{s: '0, c: 1'b0, o: 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_done%0d", i), 32'(done), 32'd0);
    end
    run(rv, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
